// File: rtl/addmod_opseq_pkg.sv
// Shared types and constants for the modular-adder operand sequencer.
// Word and address widths, the FSM state encoding and the command latency.
package addmod_opseq_pkg;

  localparam int WORD_SIZE = 64;
  localparam int ADDR_W    = 8;
  localparam int LATENCY   = 9;

  typedef logic [WORD_SIZE-1:0]   word_t;
  typedef logic [2*WORD_SIZE-1:0] dword_t;
  typedef logic [ADDR_W-1:0]      addr_t;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RD0  = 4'd1,
    S_RD1  = 4'd2,
    S_RD2  = 4'd3,
    S_RD3  = 4'd4,
    S_RD4  = 4'd5,
    S_EXEC = 4'd6,
    S_WR0  = 4'd7,
    S_WR1  = 4'd8,
    S_DONE = 4'd9
  } state_t;

endpackage

// File: rtl/addmod_opseq_if.sv
// Command, RAM and adder bus of the operand sequencer.
// slave is the sequencer's view, master the surrounding datapath's view.
interface addmod_opseq_if;
  import addmod_opseq_pkg::*;

  logic   start;
  addr_t  addr_a;
  addr_t  addr_b;
  addr_t  addr_d;
  logic   ready;
  logic   done;
  addr_t  ram_addr;
  logic   ram_we;
  word_t  ram_wdata;
  word_t  ram_rdata;
  dword_t add_a;
  dword_t add_b;
  dword_t add_res;

  modport slave (
    input  start, addr_a, addr_b, addr_d,
    input  ram_rdata, add_res,
    output ready, done,
    output ram_addr, ram_we, ram_wdata,
    output add_a, add_b
  );

  modport master (
    output start, addr_a, addr_b, addr_d,
    output ram_rdata, add_res,
    input  ready, done,
    input  ram_addr, ram_we, ram_wdata,
    input  add_a, add_b
  );

endinterface

// File: rtl/addmod_opseq.sv
// Reads two double-word operands from RAM, feeds the external modular
// adder, and writes the registered sum back as two words.
module addmod_opseq
  import addmod_opseq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  addmod_opseq_if.slave bus
);

  state_t state;
  addr_t  a_q;
  addr_t  b_q;
  addr_t  d_q;
  word_t  a_lo;
  word_t  a_hi;
  word_t  b_lo;
  word_t  b_hi;
  dword_t res_q;
  logic   ready_q;
  logic   done_q;
  addr_t  addr_q;
  logic   we_q;
  word_t  wdata_q;

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.add_a     = {a_hi, a_lo};
  assign bus.add_b     = {b_hi, b_lo};

  // Sequencer FSM; outputs are set on entry so each state sees them registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      a_lo    <= '0;
      a_hi    <= '0;
      b_lo    <= '0;
      b_hi    <= '0;
      res_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.addr_a;
            b_q     <= bus.addr_b;
            d_q     <= bus.addr_d;
            addr_q  <= bus.addr_a;
            ready_q <= 1'b0;
            state   <= S_RD0;
          end
        end
        S_RD0: begin
          addr_q <= a_q + addr_t'(1);
          state  <= S_RD1;
        end
        S_RD1: begin
          a_lo   <= bus.ram_rdata;
          addr_q <= b_q;
          state  <= S_RD2;
        end
        S_RD2: begin
          a_hi   <= bus.ram_rdata;
          addr_q <= b_q + addr_t'(1);
          state  <= S_RD3;
        end
        S_RD3: begin
          b_lo  <= bus.ram_rdata;
          state <= S_RD4;
        end
        S_RD4: begin
          b_hi  <= bus.ram_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_q   <= bus.add_res;
          addr_q  <= d_q;
          we_q    <= 1'b1;
          wdata_q <= bus.add_res[WORD_SIZE-1:0];
          state   <= S_WR0;
        end
        S_WR0: begin
          addr_q  <= d_q + addr_t'(1);
          wdata_q <= res_q[2*WORD_SIZE-1:WORD_SIZE];
          state   <= S_WR1;
        end
        S_WR1: begin
          we_q   <= 1'b0;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addmod_opseq.sv
// Directed bench for addmod_opseq with a 1-cycle-latency RAM model
// and a modular adder (modulus 2^128-159).
module tb_addmod_opseq;
  import addmod_opseq_pkg::*;

  localparam logic [128:0] MODP = {1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF61};

  logic clk = 1'b0;
  logic rst = 1'b1;

  addmod_opseq_if bus ();

  addmod_opseq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  word_t mem [0:255];
  logic  pl_we = 1'b0;
  addr_t pl_addr = '0;
  word_t pl_data = '0;

  // RAM model: one write port shared by DUT and preload, registered read.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  function automatic dword_t modadd(input dword_t x, input dword_t y);
    logic [128:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= MODP) s = s - MODP;
    return s[127:0];
  endfunction

  assign bus.add_res = modadd(bus.add_a, bus.add_b);

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input addr_t a, input word_t d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  addr_t tr_addr [1:20];
  logic  tr_we   [1:20];

  task automatic run_cmd(input addr_t a, input addr_t b, input addr_t d,
                         input dword_t ea, input dword_t eb);
    int cnt;
    bit seen;
    int rdy_hi;
    logic [127:0] ga;
    logic [127:0] gb;
    logic [8:0] wv;
    addr_t a1;
    addr_t b1;
    addr_t d1;
    a1 = a + 8'd1;
    b1 = b + 8'd1;
    d1 = d + 8'd1;
    for (int i = 1; i <= 20; i++) begin
      tr_addr[i] = '0;
      tr_we[i] = 1'b0;
    end
    ga = '0;
    gb = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr_a = a;
    bus.addr_b = b;
    bus.addr_d = d;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cnt = 0;
    seen = 0;
    rdy_hi = 0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      tr_addr[cnt] = bus.ram_addr;
      tr_we[cnt] = bus.ram_we;
      if (cnt == 6) begin
        ga = bus.add_a;
        gb = bus.add_b;
      end
      if (bus.ready) rdy_hi++;
      if (bus.done) seen = 1;
    end
    for (int i = 1; i <= 9; i++) wv[i-1] = tr_we[i];
    check("latency", seen ? 128'(cnt) : 128'd0, 128'(LATENCY));
    check("busy_ready", 128'(rdy_hi), 128'd0);
    check("rd_trace", {tr_addr[1], tr_addr[2], tr_addr[3], tr_addr[4]},
          {a, a1, b, b1});
    check("we_pattern", 128'(wv), 128'(9'b011000000));
    check("wr_addr", {tr_addr[7], tr_addr[8]}, {d, d1});
    check("add_a", ga, ea);
    check("add_b", gb, eb);
    @(negedge clk);
    check("ready_after", 128'(bus.ready), 128'd1);
  endtask

  initial begin
    int cnt;
    int ndone;
    word_t exp_b2b [0:2];
    exp_b2b[0] = 64'd8;
    exp_b2b[1] = 64'd15;
    exp_b2b[2] = 64'd22;

    bus.start = 1'b0;
    bus.addr_a = '0;
    bus.addr_b = '0;
    bus.addr_d = '0;

    // reset state
    @(negedge clk);
    check("rst_ready", 128'(bus.ready), 128'd1);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_we", 128'(bus.ram_we), 128'd0);
    check("rst_addr", 128'(bus.ram_addr), 128'd0);
    check("rst_wdata", 128'(bus.ram_wdata), 128'd0);
    check("rst_add_a", bus.add_a, 128'd0);
    check("rst_add_b", bus.add_b, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // basic
    poke(8'h10, 64'd5);
    poke(8'h11, 64'd0);
    poke(8'h20, 64'd7);
    poke(8'h21, 64'd0);
    run_cmd(8'h10, 8'h20, 8'h30, 128'd5, 128'd7);
    check("basic_lo", 128'(mem[8'h30]), 128'd12);
    check("basic_hi", 128'(mem[8'h31]), 128'd0);

    // word carry
    poke(8'h80, 64'hFFFF_FFFF_FFFF_FFFF);
    poke(8'h81, 64'd0);
    poke(8'h82, 64'd1);
    poke(8'h83, 64'd0);
    run_cmd(8'h80, 8'h82, 8'h84,
            {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 128'd1);
    check("carry_lo", 128'(mem[8'h84]), 128'd0);
    check("carry_hi", 128'(mem[8'h85]), 128'd1);

    // modular reduction: (P-1) + 2 = 1
    poke(8'h90, 64'hFFFF_FFFF_FFFF_FF60);
    poke(8'h91, 64'hFFFF_FFFF_FFFF_FFFF);
    poke(8'h92, 64'd2);
    poke(8'h93, 64'd0);
    run_cmd(8'h90, 8'h92, 8'h94,
            128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF60, 128'd2);
    check("mod_lo", 128'(mem[8'h94]), 128'd1);
    check("mod_hi", 128'(mem[8'h95]), 128'd0);

    // aliasing a=b=d
    poke(8'h40, 64'd3);
    poke(8'h41, 64'd0);
    run_cmd(8'h40, 8'h40, 8'h40, 128'd3, 128'd3);
    check("alias_lo", 128'(mem[8'h40]), 128'd6);
    check("alias_hi", 128'(mem[8'h41]), 128'd0);

    // address wrap at 0xFF for both a and d
    poke(8'hFF, 64'd9);
    poke(8'h00, 64'd2);
    run_cmd(8'hFF, 8'h20, 8'hFF, {64'd2, 64'd9}, 128'd7);
    check("wrap_lo", 128'(mem[8'hFF]), 128'd16);
    check("wrap_hi", 128'(mem[8'h00]), 128'd2);

    // busy: second start while running is dropped
    poke(8'h70, 64'hDEAD);
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr_a = 8'h10;
    bus.addr_b = 8'h20;
    bus.addr_d = 8'h60;
    @(posedge clk);
    #1 bus.start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bus.start = 1'b1;
        bus.addr_d = 8'h70;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) ndone++;
    end
    check("busy_ndone", 128'(ndone), 128'd1);
    check("busy_res", 128'(mem[8'h60]), 128'd12);
    check("busy_nowrite", 128'(mem[8'h70]), 128'hDEAD);

    // reset during WR0
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr_a = 8'h10;
    bus.addr_b = 8'h20;
    bus.addr_d = 8'hA0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= 7; i++) @(negedge clk);
    check("wr0_we", 128'(bus.ram_we), 128'd1);
    rst = 1'b1;
    #1;
    check("rst_wr0_we", 128'(bus.ram_we), 128'd0);
    check("rst_wr0_ready", 128'(bus.ready), 128'd1);
    check("rst_wr0_done", 128'(bus.done), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("rst_wr0_nodone", 128'(ndone), 128'd0);
    check("rst_wr0_idle", 128'(bus.ready), 128'd1);

    // back-to-back with start held high, accumulating into 0x50
    poke(8'h50, 64'd1);
    poke(8'h51, 64'd0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr_a = 8'h50;
    bus.addr_b = 8'h20;
    bus.addr_d = 8'h50;
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus.done && cnt < 15);
      if (k == 2) bus.start = 1'b0;
      check(k == 0 ? "b2b_first" : "b2b_period", 128'(cnt),
            k == 0 ? 128'd9 : 128'd10);
      check("b2b_lo", 128'(mem[8'h50]), 128'(exp_b2b[k]));
      check("b2b_hi", 128'(mem[8'h51]), 128'd0);
    end
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("b2b_stop", 128'(mem[8'h50]), 128'd22);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
